net_traffic_terminal: RTL

- Endpoint attached to one port of the multi-port test network.
- Injects a programmable burst of network messages, one per valid/ready handshake, spread round-robin over all destinations. Each message carries a per-destination sequence number in the opaque field.
- Ejects every message the network delivers to this port. Checks destination and per-source ordering, and counts received traffic.
- Used in pairs/arrays around the network for self-checking network tests.

---
 rtl/net_traffic_terminal.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/net_traffic_terminal.sv
// net_traffic_terminal
//   Endpoint for one port of the multi-port test network. The inject side
//   sends a programmable burst of messages, round-robin over all
//   destinations, each tagged with a per-destination sequence number in the
//   opaque field. The eject side accepts every delivered message, checks
//   destination and per-source ordering, and counts received traffic.
//   Message layout, MSB first: dest | src | opaque | payload.
//   Optional build macro NET_TERM_PAYLOAD_CHECK_EN: when defined, the eject
//   check also verifies the payload's embedded source id and zero upper bits.
module net_traffic_terminal #(
  parameter int p_num_ports     = 4,
  parameter int p_payload_nbits = 32,
  parameter int p_opaque_nbits  = 3,
  parameter int p_srcdest_nbits = 3
) (
  input  logic                                                          clk,
  input  logic                                                          reset,
  input  logic [p_srcdest_nbits-1:0]                                    src_id,
  input  logic                                                          go,
  input  logic [15:0]                                                   num_msgs,
  output logic                                                          out_val,
  input  logic                                                          out_rdy,
  output logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0]   out_msg,
  input  logic                                                          in_val,
  output logic                                                          in_rdy,
  input  logic [p_payload_nbits+p_opaque_nbits+2*p_srcdest_nbits-1:0]   in_msg,
  output logic                                                          done,
  output logic [15:0]                                                   tx_count,
  output logic [15:0]                                                   rx_count,
  output logic                                                          err,
  output logic [p_srcdest_nbits-1:0]                                    err_src
);

  localparam int          P  = p_payload_nbits;
  localparam int          O  = p_opaque_nbits;
  localparam int          S  = p_srcdest_nbits;
  localparam int          MW = P + O + 2 * S;
  localparam int          IW = (p_num_ports > 1) ? $clog2(p_num_ports) : 1;
  localparam logic [31:0] NP = 32'(p_num_ports);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;

  logic [15:0]     num_msgs_q;
  logic [15:0]     tx_count_q;
  logic [IW-1:0]   dest_q;
  logic [O-1:0]    tx_seq_q [p_num_ports];

  logic            in_rdy_q;
  logic [15:0]     rx_count_q;
  logic [O-1:0]    rx_seq_q [p_num_ports];
  logic            err_q;
  logic [S-1:0]    err_src_q;

  logic            start;
  logic            tx_fire;
  logic            last_tx;
  logic [P-1:0]    tx_payload;

  logic [S-1:0]    rx_dest;
  logic [S-1:0]    rx_src;
  logic [O-1:0]    rx_opq;
  logic [IW-1:0]   rx_idx;
  logic            rx_fire;
  logic            rx_src_ok;
  logic            rx_bad;

  // A burst starts on go from any state other than SEND (go is ignored mid-burst).
  assign start   = go && (state_q != ST_SEND);
  assign tx_fire = (state_q == ST_SEND) && out_rdy;
  assign last_tx = (tx_count_q + 16'd1) == num_msgs_q;

  // ---------------------------------------------------------------------
  // Inject FSM
  // ---------------------------------------------------------------------

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start from IDLE/DONE, finish on the last accepted message.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) state_d = (num_msgs == 16'd0) ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (tx_fire && last_tx) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: valid while sending, done while parked in DONE.
  always_comb begin
    out_val = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_SEND: out_val = 1'b1;
      ST_DONE: done    = 1'b1;
      default: ;
    endcase
  end

  // Burst bookkeeping: burst length, message index, round-robin dest, per-dest sequence.
  // NOTE: the sequence tables are reset element by element because their
  // reset value is architecturally visible in the first message of a burst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_msgs_q <= '0;
      tx_count_q <= '0;
      dest_q     <= '0;
      for (int i = 0; i < p_num_ports; i++) tx_seq_q[i] <= '0;
    end else if (start) begin
      num_msgs_q <= num_msgs;
      tx_count_q <= '0;
      dest_q     <= '0;
      for (int i = 0; i < p_num_ports; i++) tx_seq_q[i] <= '0;
    end else if (tx_fire) begin
      tx_count_q       <= tx_count_q + 16'd1;
      dest_q           <= (dest_q == IW'(p_num_ports - 1)) ? '0 : dest_q + IW'(1);
      tx_seq_q[dest_q] <= tx_seq_q[dest_q] + O'(1);
    end
  end

  // Injected payload: zero-extended {src_id, message index}.
  always_comb begin
    tx_payload             = '0;
    tx_payload[16+S-1:0]   = {src_id, tx_count_q};
  end

  // Message is a pure function of registered state, so it holds while stalled.
  assign out_msg  = {S'(dest_q), src_id, tx_seq_q[dest_q], tx_payload};
  assign tx_count = tx_count_q;

  // ---------------------------------------------------------------------
  // Eject checker
  // ---------------------------------------------------------------------

  assign rx_dest   = in_msg[MW-1 -: S];
  assign rx_src    = in_msg[P+O+S-1 -: S];
  assign rx_opq    = in_msg[P+O-1 -: O];
  assign rx_idx    = rx_src[IW-1:0];
  assign rx_fire   = in_val && in_rdy_q;
  assign rx_src_ok = 32'(rx_src) < NP;

`ifndef NET_TERM_PAYLOAD_CHECK_EN
  // Payload is deliberately not inspected in this build.
  logic unused_payload;
  assign unused_payload = ^in_msg[P-1:0];
`endif

  // Per-message error decode: bad source, wrong destination, out-of-order sequence.
  always_comb begin
    rx_bad = 1'b0;
    if (!rx_src_ok)                           rx_bad = 1'b1;
    else if (rx_opq != rx_seq_q[rx_idx])      rx_bad = 1'b1;
    if (rx_dest != src_id)                    rx_bad = 1'b1;
`ifdef NET_TERM_PAYLOAD_CHECK_EN
    if (in_msg[16+S-1:16] != rx_src)          rx_bad = 1'b1;
    if ((in_msg[P-1:0] >> (16 + S)) != '0)    rx_bad = 1'b1;
`endif
  end

  // Sink state: always ready, counts traffic, resyncs per-source sequence, sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_rdy_q   <= 1'b0;
      rx_count_q <= '0;
      err_q      <= 1'b0;
      err_src_q  <= '0;
      for (int i = 0; i < p_num_ports; i++) rx_seq_q[i] <= '0;
    end else begin
      in_rdy_q <= 1'b1;
      if (rx_fire) begin
        rx_count_q <= rx_count_q + 16'd1;
        // Resync to the observed sequence even on error; unknown sources leave the table alone.
        if (rx_src_ok) rx_seq_q[rx_idx] <= rx_opq + O'(1);
        // Only the first failure is recorded.
        if (rx_bad && !err_q) begin
          err_q     <= 1'b1;
          err_src_q <= rx_src;
        end
      end
    end
  end

  assign in_rdy   = in_rdy_q;
  assign rx_count = rx_count_q;
  assign err      = err_q;
  assign err_src  = err_src_q;

endmodule
